// File: rtl/competition_engine.sv
// Quiz-competition controller: buzz arbitration, judging with optional
// rebound, per-question ms timer, saturating scores and winner selection.
module competition_engine #(
  parameter int MAX_PLAYERS   = 4,
  parameter int MAX_QUESTIONS = 9,
  parameter int SCORE_W       = 7,
  parameter int CLK_PER_MS    = 100_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               start,
  input  logic [MAX_PLAYERS-1:0]             buzz,
  input  logic                               judge_ok,
  input  logic                               judge_fail,
  input  logic                               judge_skip,
  input  logic                               rebound_en,
  input  logic [3:0]                         player_count,
  input  logic [3:0]                         question_count,
  input  logic [6:0]                         answer_time,
  input  logic [SCORE_W-1:0]                 win_score,
  input  logic [3:0]                         success_score,
  input  logic [3:0]                         fail_score,
  output logic [1:0]                         state,
  output logic [3:0]                         play_count,
  output logic [16:0]                        time_remain,
  output logic [MAX_PLAYERS*SCORE_W-1:0]     scores,
  output logic [MAX_PLAYERS*2*MAX_QUESTIONS-1:0] results,
  output logic [3:0]                         select_player,
  output logic [3:0]                         winner,
  output logic                               tie,
  output logic                               timeout
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int RW = 2 * MAX_QUESTIONS;
  localparam int EW = ((SCORE_W > 4) ? SCORE_W : 4) + 2;
  localparam logic [PW-1:0]      PRESC_MAX = PW'(CLK_PER_MS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUZZ = 2'd1, JUDGE = 2'd2, DONE = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [3:0]         pc_q, pc_d;
  logic [16:0]        tr_q, tr_d;
  logic [SCORE_W-1:0] score_q [MAX_PLAYERS];
  logic [SCORE_W-1:0] score_d [MAX_PLAYERS];
  logic [RW-1:0]      res_q [MAX_PLAYERS];
  logic [RW-1:0]      res_d [MAX_PLAYERS];
  logic [3:0]         sel_q, sel_d;
  logic [3:0]         win_q, win_d;
  logic               tie_q, tie_d;
  logic               to_q, to_d;
  logic [MAX_PLAYERS-1:0] att_q, att_d;
  logic [PW-1:0]      presc_q, presc_d;

  logic [MAX_PLAYERS-1:0] active, elig, ebuzz, sel_vec, att_fail;
  logic [3:0]         first_idx, best_idx, cur_q;
  logic [SCORE_W-1:0] best_s;
  logic               best_found, tie_c, finish, remain, judge_one;
  logic [1:0]         code;
  logic [16:0]        load;

  // Saturating score increment: clamps at the all-ones score.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                  input logic [3:0] inc);
    logic [EW-1:0] sum;
    sum = EW'(s) + EW'(inc);
    if (sum > EW'(SCORE_MAX)) return SCORE_MAX;
    return sum[SCORE_W-1:0];
  endfunction

  // Saturating score decrement: clamps at zero.
  function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] s,
                                                  input logic [3:0] dec);
    logic signed [EW-1:0] diff;
    diff = $signed(EW'(s)) - $signed(EW'(dec));
    if (diff < 0) return '0;
    return diff[SCORE_W-1:0];
  endfunction

  assign load      = 17'(answer_time) * 17'd1000;
  assign cur_q     = pc_q - 4'd1;
  assign judge_one = $onehot({judge_ok, judge_fail, judge_skip});
  assign code      = judge_ok ? 2'b01 : (judge_fail ? 2'b10 : 2'b11);

  // Player eligibility, buzz priority, leader search and finish condition.
  always_comb begin
    active     = '0;
    sel_vec    = '0;
    first_idx  = 4'd0;
    best_idx   = 4'd0;
    best_s     = '0;
    best_found = 1'b0;
    tie_c      = 1'b0;
    finish     = (pc_q == question_count);
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      active[i]  = (4'(i) < player_count);
      sel_vec[i] = (4'(i + 1) == sel_q);
    end
    elig     = active & ~att_q;
    ebuzz    = buzz & elig;
    att_fail = att_q | sel_vec;
    remain   = |(active & ~att_fail);
    for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
      if (ebuzz[i]) first_idx = 4'(i);
    end
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      if (active[i] && (!best_found || score_q[i] > best_s)) begin
        best_s     = score_q[i];
        best_idx   = 4'(i);
        best_found = 1'b1;
      end
      if (active[i] && score_q[i] >= win_score) finish = 1'b1;
    end
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      if (active[i] && 4'(i) != best_idx && score_q[i] == best_s) tie_c = 1'b1;
    end
  end

  // Next-state and next-output logic; enable low forces the reset image.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tr_d    = tr_q;
    score_d = score_q;
    res_d   = res_q;
    sel_d   = sel_q;
    win_d   = win_q;
    tie_d   = tie_q;
    to_d    = 1'b0;
    att_d   = att_q;
    presc_d = presc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (finish) begin
            win_d   = best_idx + 4'd1;
            tie_d   = tie_c;
            tr_d    = '0;
            state_d = DONE;
          end else begin
            pc_d    = pc_q + 4'd1;
            att_d   = '0;
            sel_d   = 4'd0;
            tr_d    = load;
            presc_d = '0;
            state_d = BUZZ;
          end
        end
      end
      BUZZ: begin
        if (|ebuzz) begin
          // A buzz beats a coinciding expiry; the timer freezes as is.
          sel_d   = first_idx + 4'd1;
          state_d = JUDGE;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          if (tr_q > 17'd1) begin
            tr_d = tr_q - 17'd1;
          end else if (tr_q == 17'd1) begin
            tr_d    = '0;
            to_d    = 1'b1;
            sel_d   = 4'd0;
            state_d = IDLE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      JUDGE: begin
        if (judge_one) begin
          for (int i = 0; i < MAX_PLAYERS; i++) begin
            if (sel_vec[i]) begin
              for (int q = 0; q < MAX_QUESTIONS; q++) begin
                if (4'(q) == cur_q) res_d[i][2*q +: 2] = code;
              end
              if (judge_ok)   score_d[i] = sat_add(score_q[i], success_score);
              if (judge_fail) score_d[i] = sat_sub(score_q[i], fail_score);
            end
          end
          if (judge_fail) begin
            att_d = att_fail;
            if (rebound_en && remain) begin
              sel_d   = 4'd0;
              tr_d    = load;
              presc_d = '0;
              state_d = BUZZ;
            end else begin
              tr_d    = '0;
              state_d = IDLE;
            end
          end else begin
            tr_d    = '0;
            state_d = IDLE;
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      pc_d    = 4'd0;
      tr_d    = '0;
      score_d = '{default: '0};
      res_d   = '{default: '0};
      sel_d   = 4'd0;
      win_d   = 4'd0;
      tie_d   = 1'b0;
      to_d    = 1'b0;
      att_d   = '0;
      presc_d = '0;
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= 4'd0;
      tr_q    <= '0;
      score_q <= '{default: '0};
      res_q   <= '{default: '0};
      sel_q   <= 4'd0;
      win_q   <= 4'd0;
      tie_q   <= 1'b0;
      to_q    <= 1'b0;
      att_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tr_q    <= tr_d;
      score_q <= score_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      win_q   <= win_d;
      tie_q   <= tie_d;
      to_q    <= to_d;
      att_q   <= att_d;
      presc_q <= presc_d;
    end
  end

  for (genvar g = 0; g < MAX_PLAYERS; g++) begin : g_pack
    assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
    assign results[g*RW +: RW]          = res_q[g];
  end

  assign state         = state_q;
  assign play_count    = pc_q;
  assign time_remain   = tr_q;
  assign select_player = sel_q;
  assign winner        = win_q;
  assign tie           = tie_q;
  assign timeout       = to_q;

endmodule

// File: tb/tb_competition_engine.sv
// Directed bench for competition_engine: per-cycle vector table for the
// buzz/judge/rebound flow plus hand sequences for timer, finish and clears.
module tb_competition_engine;

  logic        clk = 1'b0;
  logic        rst, enable, start, judge_ok, judge_fail, judge_skip, rebound_en;
  logic [3:0]  buzz, player_count, question_count, success_score, fail_score;
  logic [6:0]  answer_time, win_score;
  logic [1:0]  state;
  logic [3:0]  play_count, select_player, winner;
  logic [16:0] time_remain;
  logic [27:0] scores;
  logic [71:0] results;
  logic        tie, timeout;

  int total = 0;
  int passed = 0;
  int to_cnt = 0;
  int to_base;

  competition_engine #(.MAX_PLAYERS(4), .MAX_QUESTIONS(9), .SCORE_W(7), .CLK_PER_MS(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .buzz(buzz),
    .judge_ok(judge_ok), .judge_fail(judge_fail), .judge_skip(judge_skip),
    .rebound_en(rebound_en), .player_count(player_count), .question_count(question_count),
    .answer_time(answer_time), .win_score(win_score), .success_score(success_score),
    .fail_score(fail_score), .state(state), .play_count(play_count),
    .time_remain(time_remain), .scores(scores), .results(results),
    .select_player(select_player), .winner(winner), .tie(tie), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Count timeout pulses seen on any clock edge.
  always @(posedge clk) if (timeout) to_cnt <= to_cnt + 1;

  typedef struct {
    logic [3:0] pcnt;
    logic       reb;
    logic       st;
    logic [3:0] bz;
    logic       ok;
    logic       fl;
    logic       sk;
    logic [1:0] e_state;
    logic [3:0] e_sel;   // 15 = not checked
    logic [3:0] e_pc;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t v(input int pcnt, input int reb, input int st, input int bz,
                             input int ok, input int fl, input int sk,
                             input int es, input int esel, input int epc);
    vec_t r;
    r.pcnt = 4'(pcnt); r.reb = 1'(reb); r.st = 1'(st); r.bz = 4'(bz);
    r.ok = 1'(ok); r.fl = 1'(fl); r.sk = 1'(sk);
    r.e_state = 2'(es); r.e_sel = 4'(esel); r.e_pc = 4'(epc);
    return r;
  endfunction

  function automatic logic [6:0] sc(input int p);
    return scores[(p-1)*7 +: 7];
  endfunction

  function automatic logic [1:0] rs(input int p, input int q);
    return results[(p-1)*18 + 2*(q-1) +: 2];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0; buzz = 4'b0; judge_ok = 1'b0; judge_fail = 1'b0; judge_skip = 1'b0;
  endtask

  task automatic do_q(input logic [3:0] bz, input logic [3:0] succ);
    success_score = succ;
    start = 1'b1; step();
    buzz = bz; step();
    judge_ok = 1'b1; step();
  endtask

  task automatic en_cycle();
    enable = 1'b0; step();
    enable = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; enable = 1'b1; start = 0; buzz = 0; judge_ok = 0; judge_fail = 0;
    judge_skip = 0; rebound_en = 0; player_count = 4; question_count = 9;
    answer_time = 1; win_score = 100; success_score = 3; fail_score = 2;

    tbl[0]  = v(4,0,1,4'b0000,0,0,0, 1, 0,2);
    tbl[1]  = v(4,0,0,4'b1010,0,0,0, 2, 2,2);
    tbl[2]  = v(4,0,0,4'b0000,1,1,0, 2, 2,2);
    tbl[3]  = v(4,0,0,4'b0000,0,0,1, 0,15,2);
    tbl[4]  = v(4,0,1,4'b0000,0,0,0, 1, 0,3);
    tbl[5]  = v(3,0,0,4'b1000,0,0,0, 1, 0,3);
    tbl[6]  = v(3,0,0,4'b0001,0,0,0, 2, 1,3);
    tbl[7]  = v(3,0,0,4'b0000,1,0,0, 0,15,3);
    tbl[8]  = v(4,0,1,4'b0000,0,0,0, 1, 0,4);
    tbl[9]  = v(4,0,0,4'b0001,0,0,0, 2, 1,4);
    tbl[10] = v(4,1,0,4'b0000,0,1,0, 1, 0,4);
    tbl[11] = v(4,1,0,4'b0011,0,0,0, 2, 2,4);
    tbl[12] = v(4,1,0,4'b0000,0,1,0, 1, 0,4);
    tbl[13] = v(4,1,0,4'b0011,0,0,0, 1, 0,4);
    tbl[14] = v(4,1,0,4'b1000,0,0,0, 2, 4,4);
    tbl[15] = v(4,1,0,4'b0000,1,0,0, 0,15,4);
    tbl[16] = v(4,1,1,4'b0000,0,0,0, 1, 0,5);
    tbl[17] = v(4,1,0,4'b0001,0,0,0, 2, 1,5);
    tbl[18] = v(4,1,0,4'b0000,0,1,0, 1, 0,5);
    tbl[19] = v(4,1,0,4'b0010,0,0,0, 2, 2,5);
    tbl[20] = v(4,1,0,4'b0000,0,1,0, 1, 0,5);
    tbl[21] = v(4,1,0,4'b0010,0,0,0, 1, 0,5);
    tbl[22] = v(4,1,0,4'b0100,0,0,0, 2, 3,5);
    tbl[23] = v(4,1,0,4'b0000,0,1,0, 1, 0,5);
    tbl[24] = v(4,1,0,4'b1000,0,0,0, 2, 4,5);
    tbl[25] = v(4,1,0,4'b0000,0,1,0, 0,15,5);

    // Reset state
    repeat (3) step();
    chk("rst state", state, 0);
    chk("rst play_count", play_count, 0);
    chk("rst time_remain", time_remain, 0);
    chk("rst scores", scores, 0);
    chk("rst winner", winner, 0);
    rst = 1'b1;
    step();

    // Question 1: buzz after 10 cycles, ok
    start = 1'b1; step();
    chk("q1 state", state, 1);
    chk("q1 play_count", play_count, 1);
    chk("q1 load", time_remain, 1000);
    repeat (10) step();
    chk("q1 after 10 cycles", time_remain, 998);
    buzz = 4'b0100; step();
    chk("q1 judge state", state, 2);
    chk("q1 select", select_player, 3);
    chk("q1 frozen timer", time_remain, 998);
    judge_ok = 1'b1; step();
    chk("q1 idle", state, 0);
    chk("q1 p3 score", sc(3), 3);
    chk("q1 p3 result", rs(3,1), 1);
    chk("q1 timer cleared", time_remain, 0);

    // Table-driven per-cycle vectors
    for (int i = 0; i < 26; i++) begin
      player_count = tbl[i].pcnt; rebound_en = tbl[i].reb; start = tbl[i].st;
      buzz = tbl[i].bz; judge_ok = tbl[i].ok; judge_fail = tbl[i].fl; judge_skip = tbl[i].sk;
      step();
      chk($sformatf("row%0d state", i), state, tbl[i].e_state);
      chk($sformatf("row%0d play_count", i), play_count, tbl[i].e_pc);
      if (tbl[i].e_sel != 4'd15) chk($sformatf("row%0d select", i), select_player, tbl[i].e_sel);
    end
    rebound_en = 1'b0;
    chk("tbl score p1", sc(1), 0);
    chk("tbl score p2", sc(2), 0);
    chk("tbl score p3", sc(3), 1);
    chk("tbl score p4", sc(4), 1);
    chk("res p2 q2", rs(2,2), 3);
    chk("res p1 q3", rs(1,3), 1);
    chk("res p1 q4", rs(1,4), 2);
    chk("res p2 q4", rs(2,4), 2);
    chk("res p3 q4", rs(3,4), 0);
    chk("res p4 q4", rs(4,4), 1);
    chk("res q5 all", {rs(1,5), rs(2,5), rs(3,5), rs(4,5)}, 8'b10101010);
    chk("res p1 q1", rs(1,1), 0);

    // Timeout after 1000 ticks
    start = 1'b1; step();
    chk("to load", time_remain, 1000);
    repeat (3999) step();
    chk("to last ms", time_remain, 1);
    chk("to still buzz", state, 1);
    step();
    chk("to pulse", timeout, 1);
    chk("to idle", state, 0);
    chk("to timer", time_remain, 0);
    chk("to select", select_player, 0);
    step();
    chk("to one cycle", timeout, 0);
    chk("to no results", {rs(1,6), rs(2,6), rs(3,6), rs(4,6)}, 0);

    // Buzz coinciding with expiry
    start = 1'b1; step();
    repeat (3999) step();
    buzz = 4'b0001; step();
    chk("race state", state, 2);
    chk("race select", select_player, 1);
    chk("race no timeout", timeout, 0);
    chk("race timer frozen", time_remain, 1);
    judge_skip = 1'b1; step();

    // Unlimited time
    answer_time = 0;
    to_base = to_cnt;
    start = 1'b1; step();
    chk("unl load", time_remain, 0);
    repeat (20000) step();
    chk("unl state", state, 1);
    chk("unl no timeout", to_cnt - to_base, 0);
    buzz = 4'b0100; step();
    chk("unl select", select_player, 3);
    judge_ok = 1'b1; step();
    chk("unl p3 score", sc(3), 4);

    // Asynchronous reset mid-BUZZ
    start = 1'b1; step();
    chk("arst pre", state, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst state", state, 0);
    chk("arst play_count", play_count, 0);
    chk("arst scores", scores, 0);
    #1 rst = 1'b1;

    // Question limit reached with a tie
    question_count = 3;
    do_q(4'b0001, 4'd5);
    do_q(4'b0010, 4'd5);
    do_q(4'b0100, 4'd2);
    start = 1'b1; step();
    chk("done state", state, 3);
    chk("done winner", winner, 1);
    chk("done tie", tie, 1);
    start = 1'b1; buzz = 4'b0001; step();
    chk("done held", state, 3);
    chk("done held winner", winner, 1);
    en_cycle();
    chk("en clear state", state, 0);
    chk("en clear winner", winner, 0);
    chk("en clear tie", tie, 0);
    chk("en clear scores", scores, 0);

    // Early win on threshold
    question_count = 9; win_score = 6;
    do_q(4'b0010, 4'd6);
    start = 1'b1; step();
    chk("win state", state, 3);
    chk("win winner", winner, 2);
    chk("win tie", tie, 0);
    chk("win play_count", play_count, 1);
    en_cycle();

    // enable low while in JUDGE
    start = 1'b1; step();
    buzz = 4'b0001; step();
    chk("enj judge", state, 2);
    enable = 1'b0; step();
    chk("enj state", state, 0);
    chk("enj select", select_player, 0);
    chk("enj play_count", play_count, 0);
    enable = 1'b1;

    // Score saturation at 127
    win_score = 7'd127;
    for (int k = 0; k < 9; k++) do_q(4'b0001, 4'd15);
    chk("sat score", sc(1), 127);
    start = 1'b1; step();
    chk("sat done", state, 3);
    chk("sat winner", winner, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
